// File: rtl/rv32i_pkg.sv
//------------------------------------------------------------------------------
// Module   : rv32i_pkg
// Brief    : RV32I opcode, funct and ALU control constants shared by the issue stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_CTRL_ADD  = 4'b0000;
    localparam logic [3:0] ALU_CTRL_SUB  = 4'b1000;
    localparam logic [3:0] ALU_CTRL_SLL  = 4'b0001;
    localparam logic [3:0] ALU_CTRL_SLT  = 4'b0010;
    localparam logic [3:0] ALU_CTRL_SLTU = 4'b0011;
    localparam logic [3:0] ALU_CTRL_XOR  = 4'b0100;
    localparam logic [3:0] ALU_CTRL_SRL  = 4'b0101;
    localparam logic [3:0] ALU_CTRL_SRA  = 4'b1101;
    localparam logic [3:0] ALU_CTRL_OR   = 4'b0110;
    localparam logic [3:0] ALU_CTRL_AND  = 4'b0111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
endpackage

`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
//------------------------------------------------------------------------------
// Module   : alu_ctrl_decode
// Brief    : Combinational decode of ALU-class RV32I instructions into ALU code and operands.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_ctrl_decode
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [4:0]      rd,
    output logic            wb_en,
    output logic            illegal
);
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign w_imm_u  = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
    assign w_shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};
    assign rd       = instr[11:7];

    always_comb begin
        alu_ctrl = ALU_CTRL_ADD;
        operand1 = '0;
        operand2 = '0;
        illegal  = 1'b1;
        unique case (w_opcode)
            OPC_OP: begin
                if (w_funct7 == F7_BASE ||
                    (w_funct7 == F7_ALT && (w_funct3 == F3_ADD_SUB || w_funct3 == F3_SRL_SRA))) begin
                    illegal  = 1'b0;
                    alu_ctrl = {instr[30], w_funct3};
                    operand1 = rs1_data;
                    operand2 = rs2_data;
                end
            end
            OPC_OP_IMM: begin
                // Only shifts take instr[30] into the code; ADDI must never decode as SUB.
                if (w_funct3 == F3_SLL) begin
                    if (w_funct7 == F7_BASE) begin
                        illegal  = 1'b0;
                        alu_ctrl = {instr[30], w_funct3};
                        operand1 = rs1_data;
                        operand2 = w_shamt;
                    end
                end else if (w_funct3 == F3_SRL_SRA) begin
                    if (w_funct7 == F7_BASE || w_funct7 == F7_ALT) begin
                        illegal  = 1'b0;
                        alu_ctrl = {instr[30], w_funct3};
                        operand1 = rs1_data;
                        operand2 = w_shamt;
                    end
                end else begin
                    illegal  = 1'b0;
                    alu_ctrl = {1'b0, w_funct3};
                    operand1 = rs1_data;
                    operand2 = w_imm_i;
                end
            end
            OPC_LUI: begin
                illegal  = 1'b0;
                operand2 = w_imm_u;
            end
            OPC_AUIPC: begin
                illegal  = 1'b0;
                operand1 = pc;
                operand2 = w_imm_u;
            end
            default: ;
        endcase
    end

    assign wb_en = !illegal && (rd != 5'd0);
endmodule

`default_nettype wire

// File: rtl/alu_issue_decoder.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_decoder
// Brief    : RV32I ALU issue stage with registered valid/ready output slot and flush.
//            Optional issue/stall counters enabled by macro ALU_ISSUE_PERF_CNT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue_decoder
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [4:0]      rd,
    output logic            wb_en,
    output logic            illegal
`ifdef ALU_ISSUE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);
    logic [3:0]      w_alu_ctrl;
    logic [XLEN-1:0] w_operand1;
    logic [XLEN-1:0] w_operand2;
    logic [4:0]      w_rd;
    logic            w_wb_en;
    logic            w_illegal;
    logic            w_load;

    logic            r_valid;
    logic [3:0]      r_alu_ctrl;
    logic [XLEN-1:0] r_operand1;
    logic [XLEN-1:0] r_operand2;
    logic [4:0]      r_rd;
    logic            r_wb_en;
    logic            r_illegal;

    alu_ctrl_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .alu_ctrl (w_alu_ctrl),
        .operand1 (w_operand1),
        .operand2 (w_operand2),
        .rd       (w_rd),
        .wb_en    (w_wb_en),
        .illegal  (w_illegal)
    );

    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Payload only moves on a load, so a stalled entry stays bit-stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_ctrl <= ALU_CTRL_ADD;
            r_operand1 <= '0;
            r_operand2 <= '0;
            r_rd       <= '0;
            r_wb_en    <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_load) begin
            r_alu_ctrl <= w_alu_ctrl;
            r_operand1 <= w_operand1;
            r_operand2 <= w_operand2;
            r_rd       <= w_rd;
            r_wb_en    <= w_wb_en;
            r_illegal  <= w_illegal;
        end
    end

    assign out_valid = r_valid;
    assign alu_ctrl  = r_alu_ctrl;
    assign operand1  = r_operand1;
    assign operand2  = r_operand2;
    assign rd        = r_rd;
    assign wb_en     = r_wb_en;
    assign illegal   = r_illegal;

`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] r_issue_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_valid && out_ready && !flush && (r_issue_cnt != {CNT_W{1'b1}})) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (r_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign issue_cnt = r_issue_cnt;
    assign stall_cnt = r_stall_cnt;
`endif
endmodule

`default_nettype wire

// File: tb/tb_alu_issue_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_issue_decoder
// Brief    : Self-checking bench for alu_issue_decoder against a behavioural slot model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
`ifdef ALU_ISSUE_PERF_CNT_EN
    logic [15:0] issue_cnt;
    logic [15:0] stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference slot state
    logic        m_valid;
    logic [3:0]  m_ctrl;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [4:0]  m_rd;
    logic        m_wb;
    logic        m_ill;

    alu_issue_decoder #(.XLEN(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .operand1  (operand1),
        .operand2  (operand2),
        .rd        (rd),
        .wb_en     (wb_en),
        .illegal   (illegal)
`ifdef ALU_ISSUE_PERF_CNT_EN
        ,
        .issue_cnt (issue_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the instruction-set rules.
    function automatic void ref_decode(input logic [31:0] i, input logic [31:0] p,
                                       input logic [31:0] a, input logic [31:0] b,
                                       output logic [3:0] c, output logic [31:0] o1,
                                       output logic [31:0] o2, output logic [4:0] d,
                                       output logic w, output logic il);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        d  = i[11:7];
        c  = 4'd0; o1 = 32'd0; o2 = 32'd0; il = 1'b1;
        if (i[6:0] == 7'h33) begin
            if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                il = 1'b0; c = {i[30], f3}; o1 = a; o2 = b;
            end
        end else if (i[6:0] == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                if (f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)) begin
                    il = 1'b0; c = {i[30], f3}; o1 = a; o2 = 32'(i[24:20]);
                end
            end else begin
                il = 1'b0; c = {1'b0, f3}; o1 = a; o2 = 32'($signed(i[31:20]));
            end
        end else if (i[6:0] == 7'h37) begin
            il = 1'b0; o2 = i & 32'hFFFF_F000;
        end else if (i[6:0] == 7'h17) begin
            il = 1'b0; o1 = p; o2 = i & 32'hFFFF_F000;
        end
        w = !il && (d != 5'd0);
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(m_ctrl));
            check({tag, ".operand1"}, operand1, m_op1);
            check({tag, ".operand2"}, operand2, m_op2);
            check({tag, ".rd"},       32'(rd), 32'(m_rd));
            check({tag, ".wb_en"},    32'(wb_en), 32'(m_wb));
            check({tag, ".illegal"},  32'(illegal), 32'(m_ill));
        end
    endtask

    // One clock: drive at negedge, check in_ready, advance model, check after edge.
    task automatic step(input string tag, input logic v, input logic [31:0] ins,
                        input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, input logic fl);
        logic ld;
        @(negedge clk);
        in_valid = v; instr = ins; pc = p; rs1_data = a; rs2_data = b;
        out_ready = ordy; flush = fl;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || ordy));
        ld = v && (!m_valid || ordy) && !fl;
        if (fl) m_valid = 1'b0;
        else if (ld) begin
            m_valid = 1'b1;
            ref_decode(ins, p, a, b, m_ctrl, m_op1, m_op2, m_rd, m_wb, m_ill);
        end else if (ordy) m_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        int m;
        r = $urandom;
        k = $urandom_range(0, 9);
        m = $urandom_range(0, 3);
        if (k <= 5) begin
            r[6:0] = (k <= 2) ? 7'h33 : 7'h13;
            if (m <= 1) r[31:25] = 7'h00;
            else if (m == 2) r[31:25] = 7'h20;
        end else if (k == 6) r[6:0] = 7'h37;
        else if (k == 7) r[6:0] = 7'h17;
        else if (k == 8) r[6:0] = 7'h63;
        return r;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        m_valid = 1'b0; m_ctrl = '0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_wb = 1'b0; m_ill = 1'b0;
        #12;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.alu_ctrl",  32'(alu_ctrl), 32'd0);
        check("reset.operand1",  operand1, 32'd0);
        check("reset.operand2",  operand2, 32'd0);
        check("reset.rd",        32'(rd), 32'd0);
        check("reset.wb_en",     32'(wb_en), 32'd0);
        check("reset.illegal",   32'(illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        step("addi", 1, 32'h00A00093, 0, 0, 0, 1, 0);
        check("addi.op2_const", operand2, 32'd10);
        check("addi.rd_const", 32'(rd), 32'd1);
        step("sub", 1, 32'h40208133, 0, 20, 10, 1, 0);
        check("sub.ctrl_const", 32'(alu_ctrl), 32'h8);
        step("srai", 1, 32'h4050D193, 0, 32'h8000_0000, 0, 1, 0);
        check("srai.ctrl_const", 32'(alu_ctrl), 32'hD);
        check("srai.op2_const", operand2, 32'd5);
        step("lui", 1, 32'h123450B7, 0, 32'hDEAD, 0, 1, 0);
        check("lui.op2_const", operand2, 32'h12345000);
        step("auipc", 1, 32'h00001117, 32'h100, 0, 0, 1, 0);
        check("auipc.op1_const", operand1, 32'h100);
        check("auipc.op2_const", operand2, 32'h1000);
        // Hold with downstream stalled, then back-to-back replace
        step("hold0", 1, 32'h00A00093, 0, 7, 0, 0, 0);
        step("hold1", 1, 32'h00500113, 0, 1, 0, 0, 0);
        step("hold2", 1, 32'h00500113, 0, 1, 0, 0, 0);
        check("hold.in_ready_low", 32'(in_ready), 32'd0);
        step("b2b", 1, 32'h00500113, 0, 3, 0, 1, 0);
        check("b2b.op1_const", operand1, 32'd3);
        step("illegal_br", 1, 32'h00000063, 0, 5, 6, 1, 0);
        check("illegal_br.ill_const", 32'(illegal), 32'd1);
        step("illegal_f7", 1, 32'h02208133, 0, 5, 6, 1, 0);
        check("illegal_f7.wb_const", 32'(wb_en), 32'd0);
        step("nop", 1, 32'h00000013, 0, 0, 0, 1, 0);
        step("retire", 0, 0, 0, 0, 0, 1, 0);
        step("load_f", 1, 32'h00A00093, 0, 0, 0, 1, 0);
        step("flush", 1, 32'h00500113, 0, 0, 0, 0, 1);
        check("flush.valid_const", 32'(out_valid), 32'd0);

        for (int n = 0; n < 400; n++) begin
            step("rand", ($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset while an entry is held
        step("pre_rst", 1, 32'h00A00093, 0, 0, 0, 1, 0);
        check("pre_rst.valid_const", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst.out_valid", 32'(out_valid), 32'd0);
        check("async_rst.operand2",  operand2, 32'd0);
        check("async_rst.rd",        32'(rd), 32'd0);
        check("async_rst.wb_en",     32'(wb_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0;
        step("post_rst", 1, 32'h0020C0B3, 0, 9, 4, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire

// File: doc/alu_issue_decoder.md
Name: alu_issue_decoder

Overview:
Issue stage that feeds the RV32I ALU. It accepts one instruction per handshake together with the PC and the register-file read data. It decodes OP, OP-IMM, LUI and AUIPC into the 4-bit alu_ctrl code plus the two ALU operands, and holds the result in a registered valid/ready output slot. Non-ALU or malformed encodings are flagged as illegal and never enable writeback.

Parameters:
XLEN, 32, datapath width of PC, operands and register data
CNT_W, 16, width of the optional issue counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  instruction, PC and register data valid
in_ready  out  1  slot can accept; equals !out_valid || out_ready
instr  in  32  RV32I instruction word
pc  in  XLEN  PC of instr
rs1_data  in  XLEN  register-file value for instr[19:15]
rs2_data  in  XLEN  register-file value for instr[24:20]
flush  in  1  discard held and incoming entry
out_valid  out  1  decoded entry held
out_ready  in  1  ALU/writeback accepts entry
alu_ctrl  out  4  ALU operation code
operand1  out  XLEN  ALU operand 1
operand2  out  XLEN  ALU operand 2
rd  out  5  destination register
wb_en  out  1  write rd with ALU result
illegal  out  1  entry is not a legal ALU-class instruction

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high. Under reset: out_valid=0, alu_ctrl=0000, operand1=0, operand2=0, rd=0, wb_en=0, illegal=0.
- Entry load: an entry is loaded on a clk edge when in_valid && in_ready && !flush. Outputs then update on that edge, giving 1-cycle latency.
- Entry hold: if out_valid && !out_ready, every output holds stable and in_ready=0.
- Back-to-back transfer: if out_ready=1 and in_valid=1 in the same cycle, the held entry retires and the new entry loads on the same edge, giving full throughput.
- Retire without refill: if out_ready=1 and in_valid=0, out_valid clears on the next edge.
- Flush: flush has priority over everything except reset. On the next edge out_valid=0 and the incoming entry is dropped. in_ready is unaffected by flush.
- ALU codes: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- OP (0110011):
  - alu_ctrl={instr[30],funct3}; operand1=rs1_data; operand2=rs2_data.
  - Legal when funct7=0000000, or when funct7=0100000 with funct3 000 or 101.
- OP-IMM (0010011):
  - operand1=rs1_data; operand2=sign-extended instr[31:20].
  - For funct3 001 and 101: operand2={27'b0,instr[24:20]} and alu_ctrl={instr[30],funct3}. funct3=001 requires funct7=0; funct3=101 requires funct7 0000000 or 0100000.
  - For all other funct3: alu_ctrl={1'b0,funct3}, so ADDI never becomes SUB.
- LUI (0110111): alu_ctrl=ADD, operand1=0, operand2={instr[31:12],12'b0}.
- AUIPC (0010111): alu_ctrl=ADD, operand1=pc, operand2={instr[31:12],12'b0}.
- Legal entries: wb_en=(rd!=0), illegal=0.
- Other opcodes and illegal funct7 encodings: illegal=1, wb_en=0, alu_ctrl=ADD, operand1=operand2=0, rd still captured from instr[11:7]. The entry still occupies the slot and follows the normal handshake.
- rd=0 (e.g. NOP): legal, and wb_en=0.

Optional Feature:
- Macro: ALU_ISSUE_PERF_CNT_EN.
- Enabled:
  - Adds outputs issue_cnt[CNT_W] and stall_cnt[CNT_W], both reset to 0.
  - issue_cnt increments on each output retire (out_valid&&out_ready&&!flush).
  - stall_cnt increments each cycle with out_valid&&!out_ready.
  - Both saturate at all-ones.
- Disabled: the ports and logic are absent, with identical other behaviour.

Decomposition:
- Shared package rv32i_pkg:
  - opcode constants: OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC;
  - ALU_CTRL_* constants (the 4-bit codes above);
  - funct7 constants F7_BASE and F7_ALT.
- Sub-module alu_ctrl_decode (purely combinational): instr, pc, rs1_data, rs2_data -> alu_ctrl, operand1, operand2, rd, wb_en, illegal. Top level holds the output slot, handshake, flush and counters.

Test Plan:
- Reset released; input 0x00A00093 (addi x1,x0,10), rs1_data=0 -> next cycle alu_ctrl=0000, op1=0, op2=10, rd=1, wb_en=1.
- 0x40208133 (sub x2,x1,x2), rs1=20, rs2=10 -> alu_ctrl=1000, op1=20, op2=10; 0x4050D193 (srai x3,x1,5) -> alu_ctrl=1101, op2=5.
- LUI 0x123450B7 -> op1=0, op2=0x12345000, alu_ctrl=0000. AUIPC 0x00001117 with pc=0x100 -> op1=0x100, op2=0x1000.
- out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Then out_ready=1 with new input -> retire and load on the same edge, no bubble.
- Illegal encodings 0x00000063 (branch) and 0x02208133 (funct7=0000001) -> illegal=1, wb_en=0, alu_ctrl=0000, op1=op2=0.
- flush asserted with held entry and in_valid=1 -> out_valid=0 next cycle. rst pulsed while out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge.
